branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Sits beside the fetch stage and feeds it `predict_taken` and `predicted_address` for the current fetch PC.
- Trained by resolved branch/JAL outcomes returned from the EX/MEM stage.
- Lookup is zero-latency; training takes effect one cycle later.

Parameters:
- CORE, 0, core ID used in report output.
- ADDRESS_BITS, 20, byte-address width.
- INDEX_BITS, 6, log2 of BTB entry count (64 entries).

Ports:
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- lookup_PC  input  ADDRESS_BITS  current fetch PC, byte address
- predict_taken  output  1  lookup hit AND counter predicts taken
- predicted_address  output  ADDRESS_BITS  predicted next PC
- update_valid  input  1  resolved control-transfer outcome present this cycle
- update_PC  input  ADDRESS_BITS  PC of the resolved instruction
- update_taken  input  1  actual direction
- update_target  input  ADDRESS_BITS  actual taken target
- update_predicted_taken  input  1  prediction that was carried down the pipeline with this instruction
- stat_updates  output  32  update count (see optional feature)
- stat_mispredicts  output  32  misprediction count (see optional feature)
- report  input  1  print state when high

Behaviour:
- Address split: index = PC[INDEX_BITS+1:2]; tag = PC[ADDRESS_BITS-1:INDEX_BITS+2]; PC[1:0] ignored.
- Per entry: valid (1b), tag, target (ADDRESS_BITS), counter (2b). All are flop arrays, not SRAM.
- Lookup is combinational from registered state:
  - hit = valid[idx] & (tag[idx] == lookup tag).
  - predict_taken = hit & counter[idx][1] & !reset.
  - predicted_address = predict_taken ? target[idx] : lookup_PC + 4, truncated modulo 2^ADDRESS_BITS (0xFFFFC+4 → 0x00000).
- Update on posedge when update_valid & !reset, indexed by update_PC:
  - Hit, taken: counter saturating-increments (11 stays 11); target <= update_target.
  - Hit, not taken: counter saturating-decrements (00 stays 00); target unchanged.
  - Miss, taken: allocate. valid=1, tag written, target=update_target, counter=2'b10. Any aliasing entry is overwritten.
  - Miss, not taken: no state change.
- Update and lookup to the same index in the same cycle: lookup returns pre-update contents; the new value is visible the next cycle.
- Only one update per cycle; no backpressure, update is always accepted.
- Reset:
  - All valid bits and counters are cleared to 0 in one cycle.
  - Tags and targets are don't-care.
  - predict_taken=0 while reset is high.
  - Reset mid-training discards any update in that cycle.
- Report: when report is high, display cycle count, lookup_PC, hit, counter, predict_taken, predicted_address and the update fields.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- Defined:
  - stat_updates increments on every accepted update.
  - stat_mispredicts increments when update_taken != update_predicted_taken.
  - Both are 32-bit, wrap at 2^32, and reset to 0. Counters update on the same edge as the BTB.
  - Both values are included in report output.
- Undefined: stat_updates and stat_mispredicts are tied to 0; no counter flops.

Test Plan:
- Reset, then lookup_PC=0x00100 → predict_taken=0, predicted_address=0x00104.
- Update PC=0x00040, taken, target=0x00080; next cycle lookup 0x00040 → predict_taken=1, predicted_address=0x00080, counter=10.
- Saturation on 0x00040:
  - Two not-taken updates → counter 00; lookup → 0/0x00044.
  - Third not-taken → counter stays 00.
  - Two taken updates → 01 then 10; predict_taken goes 0 then 1.
- Aliasing: update PC=0x00140 (same index 0x10, tag 0x001), taken, target=0x00200:
  - lookup 0x00040 → miss, 0/0x00044.
  - lookup 0x00140 → 1/0x00200.
- Not-taken update on empty PC=0x00300 → lookup 0x00300 → 0/0x00304. Same-cycle update+lookup of a new entry → old (miss) result that cycle, hit the next cycle.
- Stats and mid-run reset:
  - With BRANCH_PREDICTOR_STATS_EN: 3 updates with predicted/actual pairs (1,1), (0,1), (1,1) → stat_updates=3, stat_mispredicts=1.
  - Assert reset → counts 0 and all prior entries miss.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with a 2-bit
// saturating direction counter per entry. Lookup is combinational from
// registered state; training from resolved branches lands on the next edge.
// Optional build macro: BRANCH_PREDICTOR_STATS_EN enables the 32-bit update
// and misprediction counters (otherwise both outputs are tied to zero).
module branch_predictor #(
  parameter int CORE         = 0,
  parameter int ADDRESS_BITS = 20,
  parameter int INDEX_BITS   = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] lookup_PC,
  output logic                    predict_taken,
  output logic [ADDRESS_BITS-1:0] predicted_address,
  input  logic                    update_valid,
  input  logic [ADDRESS_BITS-1:0] update_PC,
  input  logic                    update_taken,
  input  logic [ADDRESS_BITS-1:0] update_target,
  input  logic                    update_predicted_taken,
  output logic [31:0]             stat_updates,
  output logic [31:0]             stat_mispredicts,
  input  logic                    report
);
  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDRESS_BITS - INDEX_BITS - 2;
  localparam logic [ADDRESS_BITS-1:0] PC_STEP = ADDRESS_BITS'(4);

  logic [ENTRIES-1:0]      valid;
  logic [1:0]              counter [ENTRIES];
  logic [TAG_BITS-1:0]     tag     [ENTRIES];
  logic [ADDRESS_BITS-1:0] target  [ENTRIES];

  // Saturating direction-counter arithmetic.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic                  lookup_hit;
  logic [INDEX_BITS-1:0] update_idx;
  logic [TAG_BITS-1:0]   update_tag;
  logic                  update_hit;
  logic                  update_en;

  assign lookup_idx = lookup_PC[INDEX_BITS+1:2];
  assign lookup_tag = lookup_PC[ADDRESS_BITS-1:INDEX_BITS+2];
  assign lookup_hit = valid[lookup_idx] && (tag[lookup_idx] == lookup_tag);

  // Fall-through address wraps naturally at the address width.
  assign predict_taken     = lookup_hit && counter[lookup_idx][1] && !reset;
  assign predicted_address = predict_taken ? target[lookup_idx] : lookup_PC + PC_STEP;

  assign update_idx = update_PC[INDEX_BITS+1:2];
  assign update_tag = update_PC[ADDRESS_BITS-1:INDEX_BITS+2];
  assign update_hit = valid[update_idx] && (tag[update_idx] == update_tag);
  assign update_en  = update_valid && !reset;

  // Control state: valid bits and direction counters, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) counter[i] <= 2'b00;
    end else if (update_valid) begin
      if (update_hit) begin
        counter[update_idx] <= update_taken ? sat_inc(counter[update_idx])
                                            : sat_dec(counter[update_idx]);
      end else if (update_taken) begin
        valid[update_idx]   <= 1'b1;
        counter[update_idx] <= 2'b10;
      end
    end
  end

  // Entry data: tag and target written on any taken outcome (allocation or refresh).
  always_ff @(posedge clock) begin
    if (update_en && update_taken) begin
      tag[update_idx]    <= update_tag;
      target[update_idx] <= update_target;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  // Update and misprediction counters, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (update_valid) begin
      stat_updates <= stat_updates + 32'd1;
      if (update_taken != update_predicted_taken)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lookup_PC[1:0], update_PC[1:0], report};
`else
  assign stat_updates     = '0;
  assign stat_mispredicts = '0;

  logic unused_bits;
  assign unused_bits = ^{lookup_PC[1:0], update_PC[1:0], update_predicted_taken, report};
`endif

`ifndef SYNTHESIS
  logic [31:0] cycle_count;

  // Free-running cycle counter and state dump for simulation reports.
  always_ff @(posedge clock) begin
    if (reset) cycle_count <= '0;
    else       cycle_count <= cycle_count + 32'd1;
    if (report) begin
`ifdef BRANCH_PREDICTOR_STATS_EN
      $display("[bp core %0d] cycle=%0d lookup_PC=%h hit=%b counter=%b predict_taken=%b predicted_address=%h upd_v=%b upd_PC=%h upd_taken=%b upd_target=%h upd_pred=%b stat_updates=%0d stat_mispredicts=%0d",
               CORE, cycle_count, lookup_PC, lookup_hit, counter[lookup_idx], predict_taken,
               predicted_address, update_valid, update_PC, update_taken, update_target,
               update_predicted_taken, stat_updates, stat_mispredicts);
`else
      $display("[bp core %0d] cycle=%0d lookup_PC=%h hit=%b counter=%b predict_taken=%b predicted_address=%h upd_v=%b upd_PC=%h upd_taken=%b upd_target=%h upd_pred=%b",
               CORE, cycle_count, lookup_PC, lookup_hit, counter[lookup_idx], predict_taken,
               predicted_address, update_valid, update_PC, update_taken, update_target,
               update_predicted_taken);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed training scenarios followed
// by randomized traffic, checked against a table-based reference model.
module tb_branch_predictor;
  localparam int AB = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AB-1:0] lookup_PC = '0;
  logic          predict_taken;
  logic [AB-1:0] predicted_address;
  logic          update_valid = 1'b0;
  logic [AB-1:0] update_PC = '0;
  logic          update_taken = 1'b0;
  logic [AB-1:0] update_target = '0;
  logic          update_predicted_taken = 1'b0;
  logic [31:0]   stat_updates;
  logic [31:0]   stat_mispredicts;
  logic          report = 1'b0;

  always #5 clock = ~clock;

  branch_predictor #(.CORE(0), .ADDRESS_BITS(AB), .INDEX_BITS(6)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .lookup_PC              (lookup_PC),
    .predict_taken          (predict_taken),
    .predicted_address      (predicted_address),
    .update_valid           (update_valid),
    .update_PC              (update_PC),
    .update_taken           (update_taken),
    .update_target          (update_target),
    .update_predicted_taken (update_predicted_taken),
    .stat_updates           (stat_updates),
    .stat_mispredicts       (stat_mispredicts),
    .report                 (report)
  );

  // Reference model: one record per BTB slot, counter kept as an integer 0..3.
  int unsigned m_valid [64];
  int unsigned m_tag   [64];
  int unsigned m_target[64];
  int unsigned m_cnt   [64];
  int unsigned m_upd = 0;
  int unsigned m_mis = 0;

  typedef struct {
    logic          pt;
    logic [AB-1:0] addr;
    logic [31:0]   su;
    logic [31:0]   sm;
    int            id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic probe = 1'b0;
  int   step_id = 0;
  int   compared = 0;
  int   mismatched = 0;

  function automatic int unsigned midx(input int unsigned pc);
    return (pc / 4) % 64;
  endfunction

  function automatic int unsigned mtag(input int unsigned pc);
    return pc / 256;
  endfunction

  task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // One clock of stimulus; expected lookup result comes from pre-edge model state.
  task automatic step(input logic rst, input logic [AB-1:0] lpc, input logic uv,
                      input logic [AB-1:0] upc, input logic ut, input logic [AB-1:0] utgt,
                      input logic upt, input logic chk);
    exp_t e;
    int unsigned i;
    int unsigned t;
    logic hitm;
    @(posedge clock);
    #1;
    reset = rst; lookup_PC = lpc; update_valid = uv; update_PC = upc;
    update_taken = ut; update_target = utgt; update_predicted_taken = upt;
    step_id++;
    i = midx(int'(lpc));
    t = mtag(int'(lpc));
    hitm = !rst && (m_valid[i] != 0) && (m_tag[i] == t) && (m_cnt[i] >= 2);
    e.pt   = hitm;
    e.addr = hitm ? AB'(m_target[i]) : AB'((int'(lpc) + 4) % (1 << AB));
`ifdef BRANCH_PREDICTOR_STATS_EN
    e.su = m_upd;
    e.sm = m_mis;
`else
    e.su = 32'd0;
    e.sm = 32'd0;
`endif
    e.id = step_id;
    if (chk) sb.push_back(e);
    probe = chk;
    if (rst) begin
      for (int k = 0; k < 64; k++) begin m_valid[k] = 0; m_cnt[k] = 0; end
      m_upd = 0;
      m_mis = 0;
    end else if (uv) begin
      m_upd++;
      if (ut != upt) m_mis++;
      i = midx(int'(upc));
      t = mtag(int'(upc));
      if (m_valid[i] != 0 && m_tag[i] == t) begin
        if (ut) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_target[i] = int'(utgt);
        end else if (m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end else if (ut) begin
        m_valid[i] = 1; m_tag[i] = t; m_target[i] = int'(utgt); m_cnt[i] = 2;
      end
    end
  endtask

  task automatic look(input logic [AB-1:0] lpc);
    step(1'b0, lpc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic upd(input logic [AB-1:0] lpc, input logic [AB-1:0] upc, input logic ut,
                     input logic [AB-1:0] utgt, input logic upt);
    step(1'b0, lpc, 1'b1, upc, ut, utgt, upt, 1'b1);
  endtask

  function automatic logic [AB-1:0] rand_pc();
    return AB'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
  endfunction

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  always @(negedge clock) begin
    if (probe) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL scoreboard_empty: got output with no expectation queued");
      end else begin
        mon_e = sb.pop_front();
        cmp("predict_taken", mon_e.id, {31'd0, predict_taken}, {31'd0, mon_e.pt});
        cmp("predicted_address", mon_e.id, {12'd0, predicted_address}, {12'd0, mon_e.addr});
        cmp("stat_updates", mon_e.id, stat_updates, mon_e.su);
        cmp("stat_mispredicts", mon_e.id, stat_mispredicts, mon_e.sm);
      end
    end
  end

  initial begin
    for (int k = 0; k < 64; k++) begin
      m_valid[k] = 0; m_tag[k] = 0; m_target[k] = 0; m_cnt[k] = 0;
    end
    // Reset, then a lookup of an empty table
    step(1'b1, 20'h00000, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 20'h00100, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    look(20'h00100);
    // Allocate 0x40 -> 0x80; same-cycle lookup still sees the miss
    upd(20'h00040, 20'h00040, 1'b1, 20'h00080, 1'b0);
    look(20'h00040);
    // Saturate down, then train back up
    upd(20'h00040, 20'h00040, 1'b0, 20'h00000, 1'b1);
    upd(20'h00040, 20'h00040, 1'b0, 20'h00000, 1'b1);
    upd(20'h00040, 20'h00040, 1'b0, 20'h00000, 1'b0);
    look(20'h00040);
    upd(20'h00040, 20'h00040, 1'b1, 20'h00080, 1'b0);
    upd(20'h00040, 20'h00040, 1'b1, 20'h00080, 1'b0);
    look(20'h00040);
    // Aliasing entry at the same index evicts the old one
    upd(20'h00040, 20'h00140, 1'b1, 20'h00200, 1'b0);
    look(20'h00040);
    look(20'h00140);
    // Not-taken on an empty slot allocates nothing
    upd(20'h00300, 20'h00300, 1'b0, 20'h00abc, 1'b0);
    look(20'h00300);
    // Fall-through wraps at the address width
    look(20'hFFFFC);
    look(20'hFFFFF);
    // Statistics: three updates, one mispredicted
    step(1'b1, 20'h00500, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    upd(20'h00500, 20'h00500, 1'b1, 20'h00600, 1'b1);
    upd(20'h00500, 20'h00500, 1'b1, 20'h00600, 1'b0);
    upd(20'h00500, 20'h00500, 1'b1, 20'h00600, 1'b1);
    look(20'h00500);
    look(20'h00140);
    // Mid-run reset discards the concurrent update and clears everything
    step(1'b1, 20'h00500, 1'b1, 20'h00700, 1'b1, 20'h00800, 1'b0, 1'b1);
    look(20'h00500);
    look(20'h00140);
    look(20'h00700);
    // Randomized traffic over a small PC set so entries hit and alias
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 63) == 0), rand_pc(), 1'($urandom_range(0, 1)), rand_pc(),
           1'($urandom_range(0, 1)), AB'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
